// File: rtl/wb_block_reader_if.sv
// Wishbone classic bus bundle shared by master and slave, carrying the clock
// and synchronous active-high reset alongside the bus signals.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;
  logic        rty;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output adr, dat_ms, sel, we, stb, cyc, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, sel, we, stb, cyc, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_block_reader.sv
// Wishbone block reader: single read cycles over a contiguous word range,
// buffered into a FIFO and presented on a valid/ready stream.
// Optional bus watchdog enabled by defining WB_READER_TIMEOUT_EN.
module wb_block_reader #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  wshb_if.master           wb_m,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] nwords,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, HOLD, FINISH} state_t;

  state_t           state_q, state_d;
  logic [31:0]      adr_q, adr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             gap_q, gap_d;
  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             valid_q;
  logic             space, stb, push, pop, timeout;

`ifdef WB_READER_TIMEOUT_EN
  logic [7:0] wd_q;

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst || !stb || wb_m.ack || wb_m.err || wb_m.rty) wd_q <= '0;
    else                                                     wd_q <= wd_q + 8'd1;
  end

  assign timeout = (wd_q == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  // Only one word is ever in flight, so "free entries counting the word in
  // flight" reduces to the FIFO not being full.
  assign space = (count_q != DEPTH_C);
  assign stb   = (state_q == READ) && space && !gap_q && !timeout;
  assign pop   = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    gap_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          adr_d   = {base_adr[31:2], 2'b00};
          rem_d   = nwords;
          err_d   = 1'b0;
          state_d = (nwords == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (!space) begin
          state_d = HOLD;
        end else if (stb) begin
          if (wb_m.err) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else if (wb_m.rty) begin
            gap_d = 1'b1;
          end else if (wb_m.ack) begin
            push  = 1'b1;
            adr_d = adr_q + 32'd4;
            rem_d = rem_q - 1'b1;
            if (rem_d == '0)                                state_d = FINISH;
            else if ((count_q == DEPTH_C - 1'b1) && !pop)   state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (space) state_d = READ;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      gap_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  always_ff @(posedge wb_m.clk) begin
    if (push) fifo_q[wr_ptr_q] <= wb_m.dat_sm;
  end

  assign wb_m.cyc    = stb;
  assign wb_m.stb    = stb;
  assign wb_m.adr    = adr_q;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.dat_ms = '0;
  assign wb_m.cti    = 3'b000;
  assign wb_m.bte    = 2'b00;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign err_flag  = err_q;
  assign out_valid = valid_q;
  assign out_data  = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_wb_block_reader.sv
// Self-checking bench for wb_block_reader: BRAM-like slave with rty/err
// injection and random latency, scoreboard of expected stream words.
`timescale 1ns/1ps
module tb_wb_block_reader;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wshb_if bus (.clk(clk), .rst(rst));

  logic        start;
  logic [31:0] base_adr;
  logic [15:0] nwords;
  logic        busy, done, err_flag;
  logic [31:0] out_data;
  logic        out_valid, out_ready;

  wb_block_reader #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .wb_m(bus), .start(start), .base_adr(base_adr), .nwords(nwords),
    .busy(busy), .done(done), .err_flag(err_flag),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave: memory word i holds i; responds on the 2nd stb cycle (plus
  // optional random wait states), with armed one-shot rty and err addresses.
  logic [31:0] err_adr = 32'hFFFF_FFFF;
  logic [31:0] rty_adr = 32'hFFFF_FFFF;
  int unsigned rty_gen = 0, rty_used_gen = 0, wait_cnt = 0;
  logic        rand_lat = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      bus.ack <= 1'b0; bus.err <= 1'b0; bus.rty <= 1'b0; wait_cnt <= 0;
    end else begin
      bus.ack <= 1'b0; bus.err <= 1'b0; bus.rty <= 1'b0;
      if (bus.cyc && bus.stb && !(bus.ack || bus.err || bus.rty)) begin
        if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
        else begin
          if (bus.adr == err_adr) bus.err <= 1'b1;
          else if (bus.adr == rty_adr && rty_used_gen != rty_gen) begin
            bus.rty <= 1'b1; rty_used_gen <= rty_gen;
          end else begin
            bus.ack <= 1'b1; bus.dat_sm <= {2'b00, bus.adr[31:2]};
          end
          wait_cnt <= rand_lat ? $urandom_range(2, 0) : 0;
        end
      end
    end
  end

  // Consumer ready driver: 0 = held low, 1 = held high, 2 = random.
  int unsigned ready_mode = 1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(1, 0));
    endcase
  end

  // Reference model state
  logic [31:0] exp_words[$];
  int          out_idx = 0;
  int unsigned occ = 0, cyc_n = 0, done_cnt = 0, ack_cnt = 0, cyc_hi = 0, valid_hi = 0;
  logic [31:0] log_adr[$];
  logic [1:0]  log_kind[$];
  int unsigned ack_cyc[$];
  logic        prev_done = 1'b0;
  int unsigned gap_state = 0;
  logic [31:0] gap_adr;

  always @(negedge clk) begin
    int unsigned push_n, pop_n;
    cyc_n++;
    push_n = 0; pop_n = 0;
    if (rst) begin
      occ = 0; prev_done = 1'b0; gap_state = 0;
    end else begin
      check("stb_eq_cyc", 32'(bus.stb), 32'(bus.cyc));
      check("valid_vs_model", 32'(out_valid), 32'(occ != 0));
      if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
      prev_done = done;
      if (done) done_cnt++;
      if (bus.cyc) cyc_hi++;
      if (out_valid) valid_hi++;
      if (gap_state == 2) begin
        check("rty_gap", 32'(bus.stb), 32'd0);
        gap_state = 1;
      end else if (gap_state == 1) begin
        check("rty_reissue_stb", 32'(bus.stb), 32'd1);
        check("rty_reissue_adr", bus.adr, gap_adr);
        gap_state = 0;
      end
      if (bus.stb && (bus.ack || bus.err || bus.rty)) begin
        log_adr.push_back(bus.adr);
        log_kind.push_back(bus.err ? 2'd2 : (bus.rty ? 2'd1 : 2'd0));
        if (bus.err) begin
        end else if (bus.rty) begin
          gap_state = 2; gap_adr = bus.adr;
        end else begin
          check("no_overflow", 32'(occ < DEPTH), 32'd1);
          ack_cnt++; ack_cyc.push_back(cyc_n); push_n = 1;
        end
      end
      if (out_valid && out_ready) begin
        check("out_in_model", 32'(out_idx < exp_words.size()), 32'd1);
        if (out_idx < exp_words.size()) begin
          check("out_data", out_data, exp_words[out_idx]);
          out_idx++;
        end
        pop_n = 1;
      end
      occ = occ + push_n - pop_n;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic push_exp(input logic [31:0] b, input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      exp_words.push_back(((b & 32'hFFFF_FFFC) + 32'(4 * k)) >> 2);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1; base_adr = b; nwords = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, output int unsigned lat);
    logic seen;
    seen = 1'b0; lat = 0;
    while (!seen && lat < limit) begin
      @(negedge clk); lat++; seen = done;
    end
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned lat, a0, d0, k0, c0, v0, q0;
    logic [31:0] rb;
    int unsigned rn;

    rst = 1'b1; start = 1'b0; base_adr = '0; nwords = '0;
    idle(3);
    @(negedge clk);
    check("rst_cyc", 32'(bus.cyc), 32'd0);
    check("rst_stb", 32'(bus.stb), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // Basic 4-word read
    a0 = log_adr.size(); d0 = done_cnt; k0 = ack_cyc.size();
    push_exp(32'h10, 4);
    do_start(32'h10, 16'd4);
    @(negedge clk); check("t1_busy", 32'(busy), 32'd1);
    wait_done(100, lat);
    idle(4);
    check("t1_nterm", 32'(log_adr.size() - a0), 32'd4);
    for (int unsigned i = 0; i < 4; i++) check("t1_adr", log_adr[a0 + i], 32'h10 + 32'(4 * i));
    for (int unsigned i = 1; i < 4; i++) check("t1_ack_gap", ack_cyc[k0 + i] - ack_cyc[k0 + i - 1], 32'd2);
    check("t1_done_cnt", done_cnt - d0, 32'd1);
    check("t1_err", 32'(err_flag), 32'd0);
    check("t1_drained", 32'(out_idx), 32'(exp_words.size()));

    // Zero-length transfer
    d0 = done_cnt; c0 = cyc_hi; v0 = valid_hi;
    do_start(32'h40, 16'd0);
    wait_done(10, lat);
    idle(3);
    check("t3_done_lat", 32'(lat <= 2), 32'd1);
    check("t3_no_cyc", cyc_hi - c0, 32'd0);
    check("t3_no_valid", valid_hi - v0, 32'd0);
    check("t3_done_cnt", done_cnt - d0, 32'd1);

    // Retry on word 2, error on word 3
    a0 = log_adr.size(); d0 = done_cnt;
    rty_adr = 32'h4; err_adr = 32'h8; rty_gen++;
    push_exp(32'h0, 2);
    do_start(32'h0, 16'd5);
    wait_done(100, lat);
    idle(4);
    check("t5_nterm", 32'(log_adr.size() - a0), 32'd4);
    check("t5_adr0", log_adr[a0], 32'h0);
    check("t5_kind0", 32'(log_kind[a0]), 32'd0);
    check("t5_adr1", log_adr[a0 + 1], 32'h4);
    check("t5_kind1", 32'(log_kind[a0 + 1]), 32'd1);
    check("t5_adr2", log_adr[a0 + 2], 32'h4);
    check("t5_kind2", 32'(log_kind[a0 + 2]), 32'd0);
    check("t5_adr3", log_adr[a0 + 3], 32'h8);
    check("t5_kind3", 32'(log_kind[a0 + 3]), 32'd2);
    check("t5_err", 32'(err_flag), 32'd1);
    check("t5_drained", 32'(out_idx), 32'(exp_words.size()));
    check("t5_done_cnt", done_cnt - d0, 32'd1);
    rty_adr = 32'hFFFF_FFFF; err_adr = 32'hFFFF_FFFF;
    idle(5);
    check("t5_err_sticky", 32'(err_flag), 32'd1);

    // Unaligned base, single word; err_flag clears on start
    a0 = log_adr.size();
    push_exp(32'h13, 1);
    do_start(32'h13, 16'd1);
    @(negedge clk); check("t2_err_clear", 32'(err_flag), 32'd0);
    wait_done(50, lat);
    idle(3);
    check("t2_nterm", 32'(log_adr.size() - a0), 32'd1);
    check("t2_adr", log_adr[a0], 32'h10);
    check("t2_drained", 32'(out_idx), 32'(exp_words.size()));

    // Back-pressure: FIFO fills, master holds, then resumes
    a0 = ack_cnt; d0 = done_cnt;
    ready_mode = 0;
    idle(1);
    push_exp(32'h0, 12);
    do_start(32'h0, 16'd12);
    idle(40);
    check("t4_acks_held", ack_cnt - a0, 32'd8);
    check("t4_cyc_low", 32'(bus.cyc), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    ready_mode = 1;
    wait_done(200, lat);
    idle(4);
    check("t4_acks_total", ack_cnt - a0, 32'd12);
    check("t4_drained", 32'(out_idx), 32'(exp_words.size()));
    check("t4_done_cnt", done_cnt - d0, 32'd1);

    // Reset in READ with 3 words buffered
    a0 = ack_cnt;
    ready_mode = 0;
    idle(1);
    do_start(32'h200, 16'd8);
    lat = 0;
    while (ack_cnt - a0 < 3 && lat < 50) begin tick(); lat++; end
    check("t6_three_buffered", ack_cnt - a0, 32'd3);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_cyc", 32'(bus.cyc), 32'd0);
    check("t6_stb", 32'(bus.stb), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    ready_mode = 1;
    idle(2);

    // Start during busy is ignored
    a0 = log_adr.size(); d0 = done_cnt;
    push_exp(32'h100, 4);
    do_start(32'h100, 16'd4);
    idle(2);
    do_start(32'h800, 16'd2);
    wait_done(100, lat);
    idle(4);
    check("t7_nterm", 32'(log_adr.size() - a0), 32'd4);
    for (int unsigned i = 0; i < 4; i++) check("t7_adr", log_adr[a0 + i], 32'h100 + 32'(4 * i));
    check("t7_done_cnt", done_cnt - d0, 32'd1);
    check("t7_drained", 32'(out_idx), 32'(exp_words.size()));

    // Randomised transfers with random latency and back-pressure
    rand_lat = 1'b1;
    for (int unsigned it = 0; it < 10; it++) begin
      rb = $urandom;
      if (it % 3 == 0) rb = 32'hFFFF_FFF0 | (rb & 32'hF);
      rn = $urandom_range(12, 1);
      a0 = log_adr.size(); d0 = done_cnt; q0 = exp_words.size();
      ready_mode = 2;
      push_exp(rb, rn);
      do_start(rb, 16'(rn));
      wait_done(800, lat);
      ready_mode = 1;
      lat = 0;
      while (out_idx < exp_words.size() && lat < 50) begin tick(); lat++; end
      idle(2);
      check("rand_drained", 32'(out_idx), 32'(exp_words.size()));
      check("rand_nterm", 32'(log_adr.size() - a0), rn);
      check("rand_last_adr", log_adr[log_adr.size() - 1], (rb & 32'hFFFF_FFFC) + 32'(4 * (rn - 1)));
      check("rand_done_cnt", done_cnt - d0, 32'd1);
      check("rand_err", 32'(err_flag), 32'd0);
      check("rand_nwords", 32'(exp_words.size() - q0), rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
